// File: rtl/fir_output_scaler.sv
// Output scaler for the symmetric FIR: decimate, round/shift, saturate to OutWidth, buffer in an FWFT FIFO.
// Optional build macro FIR_OUT_CONVERGENT_ROUND_EN selects round-half-to-even instead of round-half-up.
module fir_output_scaler #(
    parameter int InWidth     = 48,
    parameter int OutWidth    = 18,
    parameter int Shift       = 17,
    parameter int DecimFactor = 1,
    parameter int FifoDepth   = 4
) (
    input  logic                           Clk_i,
    input  logic                           Rstn_i,
    input  logic signed [InWidth-1:0]      Data_i,
    input  logic                           DataValid_i,
    output logic signed [OutWidth-1:0]     Data_o,
    output logic                           DataValid_o,
    input  logic                           DataReady_i,
    output logic                           Overflow_o,
    output logic                           Dropped_o,
    input  logic                           ClearFlags_i,
    output logic [$clog2(FifoDepth):0]     FifoLevel_o
);

    localparam int W1       = InWidth + 1;
    localparam int CntW     = (DecimFactor > 1) ? $clog2(DecimFactor) : 1;
    localparam int AW       = $clog2(FifoDepth);
    localparam int LvlW     = AW + 1;
    localparam int RoundAmt = (Shift > 0) ? Shift - 1 : 0;

    localparam logic signed [W1-1:0] One      = {{(W1-1){1'b0}}, 1'b1};
    localparam logic signed [W1-1:0] RoundInc = (Shift > 0) ? (One << RoundAmt) : '0;
    localparam logic signed [W1-1:0] LowMask  = (Shift > 0) ? ((One << Shift) - One) : '0;
    localparam logic signed [W1-1:0] SatMax   = {{(W1-OutWidth+1){1'b0}}, {(OutWidth-1){1'b1}}};
    localparam logic signed [W1-1:0] SatMin   = {{(W1-OutWidth+1){1'b1}}, {(OutWidth-1){1'b0}}};

    // Decimation counter
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            keep;

    assign keep = DataValid_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (DataValid_i) begin
            cnt_d = (cnt_q == CntW'(DecimFactor - 1)) ? '0 : cnt_q + CntW'(1);
        end
    end

    // Stage 1: round and arithmetic shift in InWidth+1 bits so the rounding add never wraps
    logic signed [W1-1:0] data_ext, rounded, shifted;
    logic signed [W1-1:0] s1_d, s1_q;
    logic                 s1_valid_q;

    assign data_ext = {Data_i[InWidth-1], Data_i};
    assign rounded  = data_ext + RoundInc;
    assign shifted  = rounded >>> Shift;

    always_comb begin
        s1_d = shifted;
`ifdef FIR_OUT_CONVERGENT_ROUND_EN
        // An exact tie was rounded up; clearing the LSB lands on the even neighbour.
        if ((Shift > 0) && ((data_ext & LowMask) == RoundInc)) begin
            s1_d = {shifted[W1-1:1], 1'b0};
        end
`endif
    end

    // Stage 2: saturation
    logic                        sat_hi, sat_lo, clamp;
    logic signed [OutWidth-1:0]  s2_d, s2_q;
    logic                        s2_valid_q;

    assign sat_hi = s1_q > SatMax;
    assign sat_lo = s1_q < SatMin;
    assign clamp  = s1_valid_q && (sat_hi || sat_lo);

    always_comb begin
        s2_d = s1_q[OutWidth-1:0];
        if (sat_hi) begin
            s2_d = SatMax[OutWidth-1:0];
        end else if (sat_lo) begin
            s2_d = SatMin[OutWidth-1:0];
        end
    end

    always_ff @(posedge Clk_i or negedge Rstn_i) begin
        if (!Rstn_i) begin
            cnt_q      <= '0;
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_q       <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            s1_valid_q <= keep;
            s2_valid_q <= s1_valid_q;
            if (keep) begin
                s1_q <= s1_d;
            end
            if (s1_valid_q) begin
                s2_q <= s2_d;
            end
        end
    end

    // Output FIFO. Handshake: a word transfers on a rising edge where DataValid_o && DataReady_i;
    // DataValid_o depends only on registered state, and Data_o is stable while DataValid_o is high
    // until that transfer. A write to a full FIFO is accepted only if the same edge pops.
    logic signed [OutWidth-1:0] mem_q [FifoDepth];
    logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]            level_q, level_d;
    logic                       full, pop, wr_en, drop;

    assign full  = (level_q == LvlW'(FifoDepth));
    assign pop   = (level_q != '0) && DataReady_i;
    assign wr_en = s2_valid_q && (!full || pop);
    assign drop  = s2_valid_q && full && !pop;

    always_comb begin
        level_d = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + LvlW'(1);
        end else if (!wr_en && pop) begin
            level_d = level_q - LvlW'(1);
        end
    end

    always_ff @(posedge Clk_i or negedge Rstn_i) begin
        if (!Rstn_i) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= s2_q;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

    // Sticky flags: a new event on the same edge as a clear keeps the flag set
    logic ovf_q, ovf_d, drp_q, drp_d;

    assign ovf_d = clamp || (ovf_q && !ClearFlags_i);
    assign drp_d = drop  || (drp_q && !ClearFlags_i);

    always_ff @(posedge Clk_i or negedge Rstn_i) begin
        if (!Rstn_i) begin
            ovf_q <= 1'b0;
            drp_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            drp_q <= drp_d;
        end
    end

    assign Data_o      = mem_q[rd_ptr_q];
    assign DataValid_o = (level_q != '0);
    assign FifoLevel_o = level_q;
    assign Overflow_o  = ovf_q;
    assign Dropped_o   = drp_q;

endmodule

// File: tb/tb_fir_output_scaler.sv
// Bench for fir_output_scaler: directed steps plus a randomized phase against a queue-based reference model.
module tb_fir_output_scaler;
  localparam int OutW  = 18;
  localparam int Depth = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // main instance (DecimFactor = 1)
  logic signed [47:0] data_i;
  logic               dv_i, rdy_i, clr_i;
  logic signed [17:0] data_o;
  logic               dv_o, ovf_o, drp_o;
  logic [2:0]         lvl_o;

  // decimating instance (DecimFactor = 4)
  logic signed [47:0] d_data_i;
  logic               d_dv_i, d_rdy_i, d_clr_i;
  logic signed [17:0] d_data_o;
  logic               d_dv_o, d_ovf_o, d_drp_o;
  logic [2:0]         d_lvl_o;

  fir_output_scaler u_dut (
    .Clk_i(clk), .Rstn_i(rstn), .Data_i(data_i), .DataValid_i(dv_i),
    .Data_o(data_o), .DataValid_o(dv_o), .DataReady_i(rdy_i),
    .Overflow_o(ovf_o), .Dropped_o(drp_o), .ClearFlags_i(clr_i), .FifoLevel_o(lvl_o)
  );

  fir_output_scaler #(.DecimFactor(4)) u_dec (
    .Clk_i(clk), .Rstn_i(rstn), .Data_i(d_data_i), .DataValid_i(d_dv_i),
    .Data_o(d_data_o), .DataValid_o(d_dv_o), .DataReady_i(d_rdy_i),
    .Overflow_o(d_ovf_o), .Dropped_o(d_drp_o), .ClearFlags_i(d_clr_i), .FifoLevel_o(d_lvl_o)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [OutW-1:0] exp_q[$];
  int              pipe_due[$];
  logic [OutW-1:0] pipe_val[$];
  bit              m_ovf, m_drop;
  int              cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_d(input string tag, input logic [OutW-1:0] obs, input logic [OutW-1:0] exp);
    check(tag, {46'b0, obs}, {46'b0, exp});
  endtask

  // reference: value / 2^17 rounded, then clamped to 18-bit signed; bit 18 flags a clamp
  function automatic logic [OutW:0] model(input longint x);
    longint q, r;
    logic   sat;
    q = x >>> 17;
    r = x - (q <<< 17);
`ifdef FIR_OUT_CONVERGENT_ROUND_EN
    if (r > 65536 || (r == 65536 && q[0])) q = q + 1;
`else
    if (r >= 65536) q = q + 1;
`endif
    sat = 1'b0;
    if (q > 131071) begin q = 131071; sat = 1'b1; end
    else if (q < -131072) begin q = -131072; sat = 1'b1; end
    return {sat, q[17:0]};
  endfunction

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input longint x);
    @(negedge clk);
    data_i = x[47:0];
    dv_i   = 1'b1;
    @(negedge clk);
    dv_i   = 1'b0;
  endtask

  task automatic d_strobe(input longint x);
    @(negedge clk);
    d_data_i = x[47:0];
    d_dv_i   = 1'b1;
    @(negedge clk);
    d_dv_i   = 1'b0;
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
  endtask

  // one sample through an empty FIFO with ready high: valid must appear after the third edge
  task automatic latency_check(input string tag, input longint x, input logic [OutW-1:0] exp);
    @(negedge clk);
    data_i = x[47:0];
    dv_i   = 1'b1;
    rdy_i  = 1'b1;
    @(negedge clk);
    dv_i = 1'b0;
    check({tag, "_v_e0"}, dv_o, 0);
    @(negedge clk);
    check({tag, "_v_e1"}, dv_o, 0);
    @(negedge clk);
    check({tag, "_v_e2"}, dv_o, 1);
    check_d({tag, "_data"}, data_o, exp);
    @(negedge clk);
    check({tag, "_popped"}, dv_o, 0);
  endtask

  task automatic drain_check(input string tag, input int first, input int count);
    rdy_i = 1'b1;
    for (int i = 0; i < count; i++) begin
      check_d({tag, "_data"}, data_o, OutW'(first + i));
      @(negedge clk);
    end
    rdy_i = 1'b0;
  endtask

  // one randomized cycle; called at a negedge, models the coming edge
  task automatic rand_cycle(input bit gen);
    longint      x;
    longint      raw;
    logic [OutW:0] r;
    bit          pop;
    check("rnd_level", lvl_o, exp_q.size());
    check("rnd_valid", dv_o, exp_q.size() != 0);
    raw    = longint'({$urandom, $urandom});
    x      = raw >>> $urandom_range(16, 40);
    data_i = x[47:0];
    dv_i   = gen && ($urandom_range(0, 99) < 60);
    rdy_i  = gen ? ($urandom_range(0, 99) < 50) : 1'b1;
    pop    = (exp_q.size() != 0) && rdy_i;
    if (pop) begin
      check_d("rnd_pop_data", data_o, exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (pipe_due.size() != 0 && pipe_due[0] == cyc) begin
      void'(pipe_due.pop_front());
      if (exp_q.size() < Depth) exp_q.push_back(pipe_val[0]);
      else m_drop = 1'b1;
      void'(pipe_val.pop_front());
    end
    if (dv_i) begin
      r = model(x);
      if (r[OutW]) m_ovf = 1'b1;
      pipe_due.push_back(cyc + 2);
      pipe_val.push_back(r[OutW-1:0]);
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    data_i = '0; dv_i = 1'b0; rdy_i = 1'b0; clr_i = 1'b0;
    d_data_i = '0; d_dv_i = 1'b0; d_rdy_i = 1'b0; d_clr_i = 1'b0;
    m_ovf = 1'b0; m_drop = 1'b0; cyc = 0;

    // reset state
    wait_cycles(2);
    check_d("rst_data", data_o, 0);
    check("rst_valid", dv_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_drop", drp_o, 0);
    check("rst_level", lvl_o, 0);
    rstn = 1'b1;

    // rounding and latency
    latency_check("rnd_a", 64'sh20000, 18'd1);
    latency_check("rnd_b", 64'sh30000, 18'd2);
`ifdef FIR_OUT_CONVERGENT_ROUND_EN
    latency_check("rnd_c", 64'sh10000, 18'd0);
    latency_check("rnd_d", -64'sh30000, 18'h3FFFE);
`else
    latency_check("rnd_c", 64'sh10000, 18'd1);
    latency_check("rnd_d", -64'sh30000, 18'h3FFFF);
`endif
    check("no_ovf_yet", ovf_o, 0);

    // saturation and sticky overflow
    latency_check("sat_pos", longint'(1) <<< 35, 18'h1FFFF);
    check("sat_pos_ovf", ovf_o, 1);
    latency_check("sat_neg", -(longint'(1) <<< 35), 18'h20000);
    clear_pulse();
    check("ovf_cleared", ovf_o, 0);
    @(negedge clk);
    data_i = 48'sh8_0000_0000;
    dv_i   = 1'b1;
    @(negedge clk);
    dv_i  = 1'b0;
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    check("ovf_event_wins", ovf_o, 1);
    wait_cycles(3);
    clear_pulse();
    check("ovf_cleared2", ovf_o, 0);

    // fill past depth with ready low
    rdy_i = 1'b0;
    for (int i = 1; i <= 6; i++) strobe(longint'(i) <<< 17);
    wait_cycles(4);
    check("fill_level", lvl_o, 4);
    check("fill_drop", drp_o, 1);
    check("fill_valid", dv_o, 1);
    drain_check("drain", 1, 4);
    check("drain_level", lvl_o, 0);
    check("drain_valid", dv_o, 0);

    // write into a full FIFO on the same edge as a pop
    clear_pulse();
    check("drop_cleared", drp_o, 0);
    for (int i = 1; i <= 4; i++) strobe(longint'(i) <<< 17);
    wait_cycles(4);
    check("full_level", lvl_o, 4);
    @(negedge clk);
    data_i = 48'sh7 <<< 17;
    dv_i   = 1'b1;
    @(negedge clk);
    dv_i = 1'b0;
    @(negedge clk);
    rdy_i = 1'b1;
    @(negedge clk);
    rdy_i = 1'b0;
    check("simul_level", lvl_o, 4);
    check("simul_drop", drp_o, 0);
    drain_check("simul", 2, 3);
    check_d("simul_last", data_o, 7);
    rdy_i = 1'b1;
    @(negedge clk);
    rdy_i = 1'b0;
    check("simul_empty", lvl_o, 0);

    // asynchronous reset in the middle of a drain
    strobe(longint'(1) <<< 35);
    for (int i = 5; i <= 8; i++) strobe(longint'(i) <<< 17);
    wait_cycles(4);
    check("pre_rst_ovf", ovf_o, 1);
    check("pre_rst_drop", drp_o, 1);
    check("pre_rst_level", lvl_o, 4);
    rdy_i = 1'b1;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check_d("arst_data", data_o, 0);
    check("arst_valid", dv_o, 0);
    check("arst_ovf", ovf_o, 0);
    check("arst_drop", drp_o, 0);
    check("arst_level", lvl_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    latency_check("post_rst", longint'(3) <<< 17, 18'd3);

    // decimation by 4
    rdy_i = 1'b0;
    for (int i = 1; i <= 12; i++) d_strobe(longint'(i) <<< 17);
    wait_cycles(4);
    check("dec_level", d_lvl_o, 3);
    d_rdy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_d("dec_data", d_data_o, OutW'(1 + 4 * i));
      @(negedge clk);
    end
    d_rdy_i = 1'b0;
    check("dec_empty", d_lvl_o, 0);
    for (int i = 1; i <= 6; i++) d_strobe(longint'(i) <<< 17);
    wait_cycles(4);
    check("dec_level2", d_lvl_o, 2);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("dec_rst_level", d_lvl_o, 0);
    check("dec_rst_valid", d_dv_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    d_strobe(longint'(7) <<< 17);
    wait_cycles(2);
    check("dec_after_rst_valid", d_dv_o, 1);
    check_d("dec_after_rst_data", d_data_o, 7);
    d_rdy_i = 1'b1;
    @(negedge clk);
    d_rdy_i = 1'b0;
    check("dec_after_rst_empty", d_lvl_o, 0);

    // randomized traffic against the reference queue
    @(negedge clk);
    for (int n = 0; n < 2000; n++) rand_cycle(1'b1);
    for (int n = 0; n < 12; n++) rand_cycle(1'b0);
    check("rnd_final_level", lvl_o, 0);
    check("rnd_final_ovf", ovf_o, m_ovf);
    check("rnd_final_drop", drp_o, m_drop);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
